serial_sub_ctrl: RTL

- Bit-serial subtraction controller. Sequences one 1-bit full-subtractor cell (difference = a^b^borrow; borrow = ~a&b | ~a&borrow | b&borrow) over WIDTH-bit operands, LSB first.
- Computes a - b - bin with a start/busy/done handshake.
- Sits between a requester issuing multi-bit subtracts and the single shared full-subtractor datapath.
- Trades WIDTH cycles of latency for one cell of logic.

---
 rtl/serial_sub_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a-b-bin over one full-subtractor cell, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
  logic             d_bit, br_n, last, accept;
  logic [WIDTH-1:0] res_full;
  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_n     = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    res_full = {d_bit, res_q};
    last     = cnt_q == CW'(WIDTH - 1);
    accept   = start && state_q != RUN;
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      br_d    = bin;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = res_full[WIDTH-1:1];
      br_d  = br_n;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        // After WIDTH-1 shifts bit 0 of the operand registers holds the original MSBs.
        state_d = FIN;
        diff_d  = res_full;
        bout_d  = br_n;
        ovf_d   = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == FIN;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule
